// File: rtl/rv32i_types.sv
// Shared RV32I types for the MEM-stage load/store unit: load/store funct3
// encodings, the LSU state encoding and store lane helpers.
// The optional misaligned-access trap (LSU_MISALIGN_TRAP_EN) uses is_misaligned().
package rv32i_types;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      LD_LB  = 3'b000,
      LD_LH  = 3'b001,
      LD_LW  = 3'b010,
      LD_LBU = 3'b100,
      LD_LHU = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      ST_SB = 3'b000,
      ST_SH = 3'b001,
      ST_SW = 3'b010
   } store_funct3_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } lsu_state_t;

   typedef struct packed {
      logic [3:0]      byte_enable;
      logic [XLEN-1:0] wdata;
   } store_lanes_t;

   // Byte mask and lane-shifted data for a store. Halfword lanes follow
   // offset[1] only, so a misaligned sh lands on its containing halfword.
   function automatic store_lanes_t store_lanes(input logic [2:0]      funct3,
                                                input logic [1:0]      offset,
                                                input logic [XLEN-1:0] rs2);
      store_lanes_t s;
      s.byte_enable = 4'b0000;
      s.wdata       = rs2;
      case (store_funct3_t'(funct3))
         ST_SB: begin
            s.byte_enable = 4'b0001 << offset;
            s.wdata       = {4{rs2[7:0]}};
         end
         ST_SH: begin
            s.byte_enable = 4'b0011 << {offset[1], 1'b0};
            s.wdata       = {2{rs2[15:0]}};
         end
         ST_SW:   s.byte_enable = 4'b1111;
         default: s.byte_enable = 4'b0000;
      endcase
      return s;
   endfunction

   // Halfword accesses need an even offset, word accesses a zero offset.
   function automatic logic is_misaligned(input logic [2:0] funct3,
                                          input logic [1:0] offset);
      logic mis;
      case (funct3)
         3'b001, 3'b101: mis = offset[0];
         3'b010:         mis = (offset != 2'b00);
         default:        mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword out of the
// memory word and sign- or zero-extends it. Reused by any cache bypass path.
module lsu_load_align
   import rv32i_types::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] load_data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Lane select then extension; unknown funct3 yields zero.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
      byte_v    = rdata[7:0];
      half_v    = offset[1] ? rdata[31:16] : rdata[15:0];
      load_data = '0;
      case (offset)
         2'd0:    byte_v = rdata[7:0];
         2'd1:    byte_v = rdata[15:8];
         2'd2:    byte_v = rdata[23:16];
         default: byte_v = rdata[31:24];
      endcase
      case (load_funct3_t'(funct3))
         LD_LB:   load_data = {{24{byte_v[7]}}, byte_v};
         LD_LH:   load_data = {{16{half_v[15]}}, half_v};
         LD_LW:   load_data = rdata;
         LD_LBU:  load_data = {24'd0, byte_v};
         LD_LHU:  load_data = {16'd0, half_v};
         default: load_data = '0;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one data-memory request per live
// load/store, stalls the pipeline until dmem_resp, and registers the
// extended load result for writeback.
// Optional macro LSU_MISALIGN_TRAP_EN: flag misaligned accesses on
// lsu_misalign instead of performing them force-aligned.
module mem_stage_lsu
   import rv32i_types::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_valid,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [2:0]            mem_funct3,
   input  logic [31:0]           mem_alu_out,
   input  logic [31:0]           mem_rs2_out,
   input  logic                  pipe_stall,
   input  logic                  dmem_resp,
   input  logic [31:0]           dmem_rdata,
   output logic                  dmem_read,
   output logic                  dmem_write,
   output logic [ADDR_WIDTH-1:0] dmem_address,
   output logic [31:0]           dmem_wdata,
   output logic [3:0]            dmem_byte_enable,
   output logic                  lsu_stall,
`ifdef LSU_MISALIGN_TRAP_EN
   output logic                  lsu_misalign,
`endif
   output logic [31:0]           wb_load_data
);

   lsu_state_t            state_q, state_d;
   logic                  read_q, read_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            be_q, be_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [1:0]            offset_q, offset_d;
   logic [31:0]           wb_q, wb_d;

   logic                  access;
   logic                  trap_hit;
   store_lanes_t          lanes;
   logic [31:0]           load_result;

   assign access = mem_valid & (mem_read | mem_write);
   assign lanes  = store_lanes(mem_funct3, mem_alu_out[1:0], mem_rs2_out);

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap_hit = access & is_misaligned(mem_funct3, mem_alu_out[1:0]);
`else
   assign trap_hit = 1'b0;
`endif

   lsu_load_align u_load_align (
      .rdata     (dmem_rdata),
      .offset    (offset_q),
      .funct3    (funct3_q),
      .load_data (load_result)
   );

   // Next-state, request latching and combinational stall/trap outputs.
   always_comb begin
      state_d   = state_q;
      read_d    = read_q;
      write_d   = write_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      funct3_d  = funct3_q;
      offset_d  = offset_q;
      wb_d      = wb_q;
      lsu_stall = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      lsu_misalign = 1'b0;
`endif
      case (state_q)
         IDLE: begin
`ifdef LSU_MISALIGN_TRAP_EN
            lsu_misalign = trap_hit;
`endif
            if (access && !trap_hit) begin
               lsu_stall = 1'b1;
               // A read wins when both read and write are set.
               read_d    = mem_read;
               write_d   = mem_write & ~mem_read;
               addr_d    = {mem_alu_out[ADDR_WIDTH-1:2], 2'b00};
               offset_d  = mem_alu_out[1:0];
               funct3_d  = mem_funct3;
               if (mem_read) begin
                  be_d    = 4'b0000;
                  wdata_d = '0;
               end else begin
                  be_d    = lanes.byte_enable;
                  wdata_d = lanes.wdata;
               end
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            lsu_stall = 1'b1;
            if (dmem_resp) begin
               read_d  = 1'b0;
               write_d = 1'b0;
               if (read_q) begin
                  wb_d = load_result;
               end
               state_d = DONE;
            end
         end
         DONE: begin
            // Hold here while the pipeline is frozen so the same load is not reissued.
            if (!pipe_stall) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Outputs read zero while reset is asserted.
      if (rst) begin
         lsu_stall = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         lsu_misalign = 1'b0;
`endif
      end
   end

   // State and request registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q  <= IDLE;
         read_q   <= 1'b0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         funct3_q <= '0;
         offset_q <= '0;
         wb_q     <= '0;
      end else begin
         state_q  <= state_d;
         read_q   <= read_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         funct3_q <= funct3_d;
         offset_q <= offset_d;
         wb_q     <= wb_d;
      end
   end

   assign dmem_read        = read_q;
   assign dmem_write       = write_q;
   assign dmem_address     = addr_q;
   assign dmem_wdata       = wdata_q;
   assign dmem_byte_enable = be_q;
   assign wb_load_data     = wb_q;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage of the RV32I pipeline.
- Consumes EX/MEM outputs (address, store data, funct3, read/write).
- Runs the data-memory request/response handshake and stalls the pipeline until the response arrives.
- Registers the aligned, extended load result for the writeback stage, so its output lines up with the MEM/WB stage register contents.

Parameters:
- ADDR_WIDTH, 32, width of the data-memory address bus.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- mem_valid  in  1  EX/MEM holds a live instruction.
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store.
- mem_funct3  in  3  RV32I load/store funct3.
- mem_alu_out  in  32  effective byte address.
- mem_rs2_out  in  32  store source data.
- pipe_stall  in  1  stall request from other sources, e.g. instruction fetch.
- dmem_resp  in  1  memory completion, one-cycle pulse.
- dmem_rdata  in  32  memory read word, valid with dmem_resp.
- dmem_read  out  1  read request.
- dmem_write  out  1  write request.
- dmem_address  out  ADDR_WIDTH  word-aligned address, bits [1:0]=0.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_byte_enable  out  4  store byte mask.
- lsu_stall  out  1  hold PC and all stage registers.
- wb_load_data  out  32  extended load result for WB.

Behaviour:
- Reset:
  - State is IDLE.
  - All outputs are 0.
  - Reset during ACCESS drops dmem_read/dmem_write on the same edge. The outstanding response is then ignored.
- Access definition: access = mem_valid & (mem_read | mem_write). If both mem_read and mem_write are set, the access is a read.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - When access is true, lsu_stall=1 combinationally in the same cycle.
  - At the edge, latch address, wdata, byte mask and funct3, then go to ACCESS.
  - dmem_resp is ignored in IDLE.
- ACCESS:
  - dmem_read/dmem_write are registered and held steady, along with address, data and mask, until dmem_resp.
  - lsu_stall=1 throughout.
  - On dmem_resp: capture extended data into wb_load_data (loads only; stores leave it unchanged), drop the request at the same edge, go to DONE.
  - Minimum latency: 2 cycles with a same-cycle response. Total stall = response latency + 1.
- DONE:
  - lsu_stall=0 and no new request; the stage advances.
  - If pipe_stall=1, stay in DONE and do not reissue.
  - Otherwise go to IDLE; the next instruction is evaluated there.
  - wb_load_data stays stable until the next capture, which is at least 2 cycles later, so WB reads it while the MEM/WB register holds the load.
- Store lanes (o = addr[1:0]):
  - sb: mask = 0001<<o; wdata = rs2 byte replicated/shifted to lane o.
  - sh: mask = 0011<<{o[1],0}; halfword placed in the matching lanes.
  - sw: mask = 1111.
- Load extract (lanes selected by latched o):
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
  - Illegal load funct3 (011, 110, 111) yields 0.
- Misalignment: lh/lhu/sh with o[0]=1, or lw/sw with o≠0. Default handling is to clear the low bits and perform the access (lanes per the rules above).

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- When defined:
  - Adds output lsu_misalign (1).
  - A misaligned access raises lsu_misalign for one cycle in IDLE.
  - No memory request is made and lsu_stall stays 0.
  - wb_load_data is unchanged; the FSM stays in IDLE.
- When undefined: no port, and misaligned accesses proceed force-aligned.

Decomposition:
- rv32i_types gains:
  - load_funct3_t (lb, lh, lw, lbu, lhu);
  - store_funct3_t (sb, sh, sw);
  - lsu_state_t (IDLE, ACCESS, DONE).
- Sub-module lsu_load_align: combinational; inputs rdata, offset and funct3, output the extended word. Shared with any future cache bypass path.

Test Plan:
- lw at 0x100, response after 3 cycles with rdata 0xDEADBEEF:
  - dmem_read=1, address 0x100 for 3 cycles;
  - lsu_stall high 4 cycles;
  - wb_load_data=0xDEADBEEF in DONE.
- lb at 0x203, rdata 0x80FF_1234 → wb_load_data=0xFFFFFF80. lbu at the same address → 0x00000080.
- sh at 0x302 with rs2 0x0000ABCD:
  - address 0x300, mask 1100, wdata[31:16]=0xABCD;
  - dmem_write deasserts the edge after resp.
- Load completes with pipe_stall=1 for 2 cycles in DONE → no second dmem_read; IDLE is entered after pipe_stall falls.
- rst asserted mid-ACCESS:
  - next cycle all outputs are 0 and state is IDLE;
  - a late dmem_resp is ignored and wb_load_data stays 0.
- lw at 0x101:
  - with LSU_MISALIGN_TRAP_EN: lsu_misalign pulses, no request, no stall;
  - without it: address 0x100, normal completion.
